int_sched: RTL and testbench



---
 rtl/int_sched_pkg.sv | 22 ++
 rtl/int_prio_enc.sv | 26 ++
 rtl/int_sched.sv | 183 ++++++++++++++++++
 tb/tb_int_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sched_pkg.sv
// int_sched_pkg: shared definitions for the interrupt scheduler.
//   state_e          scheduler state encoding (also visible through the EOI register read)
//   REG_*            MMIO register select values on cfg_addr
//   CAUSE_*          bit positions inside the CAUSE register
package int_sched_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StFire    = 2'd1,
      StService = 2'd2,
      StHold    = 2'd3
   } state_e;

   localparam logic [1:0] REG_MASK  = 2'd0;
   localparam logic [1:0] REG_PEND  = 2'd1;
   localparam logic [1:0] REG_CAUSE = 2'd2;
   localparam logic [1:0] REG_EOI   = 2'd3;

   localparam int unsigned CAUSE_VALID = 31;
   localparam int unsigned CAUSE_TMO   = 30;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder.
//   req  in   N_SRC  request vector (bit 0 is highest priority)
//   any  out  1      at least one request set
//   id   out  ID_W   index of the winning request (0 when none)
module int_prio_enc #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned ID_W  = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   output logic             any,
   output logic [ID_W-1:0]  id
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      any = 1'b0;
      id  = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            any = 1'b1;
            id  = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_sched.sv
// int_sched: interrupt scheduler between debounced level sources and the core.
// Rising edges on src_in are latched as pending; the highest-priority pending and
// unmasked source is delivered as one single-cycle irq_pulse, then the scheduler waits
// for a software EOI and a holdoff period before delivering the next one.
//
// Optional build macro: INT_SCHED_TIMEOUT_EN -- auto-EOI after SVC_TIMEOUT cycles in
// SERVICE, flagged in CAUSE bit 30. Without it SERVICE waits indefinitely.
//
// Ports:
//   clk        in   1      CPU clock
//   reset      in   1      synchronous, active-high reset
//   src_in     in   N_SRC  level interrupt requests
//   cfg_we     in   1      register write strobe
//   cfg_addr   in   2      0 MASK, 1 PENDING (W1C), 2 CAUSE (RO), 3 EOI / state read
//   cfg_wdata  in   32     write data
//   cfg_rdata  out  32     combinational read data for cfg_addr
//   irq_pulse  out  1      single-cycle interrupt to the core
//   irq_id     out  ID_W   delivered source id, valid while irq_pulse=1
//   busy       out  1      high in FIRE, SERVICE or HOLD
module int_sched
   import int_sched_pkg::*;
#(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned HOLDOFF     = 8,
   parameter int unsigned SVC_TIMEOUT = 1024,
   parameter int unsigned ID_W        = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_in,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output logic             irq_pulse,
   output logic [ID_W-1:0]  irq_id,
   output logic             busy
);

   localparam int unsigned HCW = $clog2(HOLDOFF + 1);

   state_e           state_q, state_d;
   logic [N_SRC-1:0] src_prev_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] rise, clr, fire_clr;
   logic [ID_W-1:0]  sel_q, sel_d;
   logic [ID_W-1:0]  enc_id;
   logic             enc_any;
   logic             cause_valid_q, cause_valid_d;
   logic             cause_tmo_q, cause_tmo_d;
   logic [ID_W-1:0]  cause_id_q, cause_id_d;
   logic [HCW-1:0]   hold_q, hold_d;
   logic             eoi_wr;
   logic             tmo_hit;

   logic unused_wdata;
   assign unused_wdata = ^cfg_wdata[31:N_SRC];

   assign rise     = src_in & ~src_prev_q;
   assign eoi_wr   = cfg_we && (cfg_addr == REG_EOI);
   assign fire_clr = (state_q == StFire) ? (N_SRC'(1) << sel_q) : '0;
   assign clr      = ((cfg_we && (cfg_addr == REG_PEND)) ? cfg_wdata[N_SRC-1:0] : '0) | fire_clr;
   // A new edge in the same cycle as a clear keeps the bit set.
   assign pend_d   = (pend_q & ~clr) | rise;
   assign mask_d   = (cfg_we && (cfg_addr == REG_MASK)) ? cfg_wdata[N_SRC-1:0] : mask_q;

   int_prio_enc #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_prio_enc (
      .req (pend_q & mask_q),
      .any (enc_any),
      .id  (enc_id)
   );

`ifdef INT_SCHED_TIMEOUT_EN
   localparam int unsigned TCW = $clog2(SVC_TIMEOUT + 1);

   logic [TCW-1:0] svc_q;

   // Counts cycles spent in SERVICE; restarts from zero on every entry.
   always_ff @(posedge clk) begin
      if (reset || (state_q != StService)) begin
         svc_q <= '0;
      end else begin
         svc_q <= svc_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == StService) && (svc_q == TCW'(SVC_TIMEOUT - 1));
`else
   localparam int unsigned UnusedSvcTimeout = SVC_TIMEOUT;

   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      hold_d        = hold_q;
      cause_valid_d = cause_valid_q;
      cause_tmo_d   = cause_tmo_q;
      cause_id_d    = cause_id_q;
      unique case (state_q)
         StIdle: begin
            if (enc_any) begin
               sel_d   = enc_id;
               state_d = StFire;
            end
         end
         StFire: begin
            cause_valid_d = 1'b1;
            cause_tmo_d   = 1'b0;
            cause_id_d    = sel_q;
            state_d       = StService;
         end
         StService: begin
            if (eoi_wr || tmo_hit) begin
               cause_valid_d = 1'b0;
               // A real EOI in the same cycle as the timeout is not a timeout.
               if (!eoi_wr) begin
                  cause_tmo_d = 1'b1;
               end
               hold_d  = HCW'(HOLDOFF - 1);
               state_d = StHold;
            end
         end
         StHold: begin
            if (hold_q == '0) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         src_prev_q    <= '0;
         pend_q        <= '0;
         mask_q        <= '0;
         sel_q         <= '0;
         hold_q        <= '0;
         cause_valid_q <= 1'b0;
         cause_tmo_q   <= 1'b0;
         cause_id_q    <= '0;
      end else begin
         state_q       <= state_d;
         src_prev_q    <= src_in;
         pend_q        <= pend_d;
         mask_q        <= mask_d;
         sel_q         <= sel_d;
         hold_q        <= hold_d;
         cause_valid_q <= cause_valid_d;
         cause_tmo_q   <= cause_tmo_d;
         cause_id_q    <= cause_id_d;
      end
   end

   assign irq_pulse = (state_q == StFire);
   assign irq_id    = irq_pulse ? sel_q : '0;
   assign busy      = (state_q != StIdle);

   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_addr)
         REG_MASK:  cfg_rdata[N_SRC-1:0] = mask_q;
         REG_PEND:  cfg_rdata[N_SRC-1:0] = pend_q;
         REG_CAUSE: begin
            cfg_rdata[CAUSE_VALID] = cause_valid_q;
            cfg_rdata[CAUSE_TMO]   = cause_tmo_q;
            cfg_rdata[ID_W-1:0]    = cause_id_q;
         end
         REG_EOI:   cfg_rdata[1:0] = state_q;
         default:   cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed scenarios plus randomized traffic for int_sched, checked against
// an event-level reference model of the scheduler kept in this bench.
module tb_int_sched;

   localparam int N       = 4;
   localparam int HOLDOFF = 8;
   localparam int SVC_TO  = 16;
   localparam int P_IDLE  = 0;
   localparam int P_FIRE  = 1;
   localparam int P_SVC   = 2;
   localparam int P_HOLD  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  src_in = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        irq_pulse;
   logic [1:0]  irq_id;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int         m_phase = P_IDLE;
   int         m_hold = 0;
   int         m_svc = 0;
   int         m_sel = 0;
   int         m_cid = 0;
   logic       m_cv = 1'b0;
   logic       m_ct = 1'b0;
   logic [3:0] m_pend = '0;
   logic [3:0] m_mask = '0;
   logic [3:0] m_prev = '0;

   int_sched #(
      .N_SRC       (N),
      .HOLDOFF     (HOLDOFF),
      .SVC_TIMEOUT (SVC_TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_in    (src_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq_pulse (irq_pulse),
      .irq_id    (irq_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advances the model by one clock using the inputs present at that edge.
   task automatic model_edge(input logic [3:0] s, input logic we, input logic [1:0] a,
                             input logic [31:0] wd, input logic r);
      logic [3:0] elig, clrm;
      int low;
      if (r) begin
         m_phase = P_IDLE; m_hold = 0; m_svc = 0; m_sel = 0; m_cid = 0;
         m_cv = 1'b0; m_ct = 1'b0; m_pend = '0; m_mask = '0; m_prev = '0;
         return;
      end
      elig = m_pend & m_mask;
      low = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) low = i;
      clrm = (we && a == 2'd1) ? wd[3:0] : 4'b0;
      if (m_phase == P_FIRE) clrm[m_sel] = 1'b1;
      if (we && a == 2'd0) m_mask = wd[3:0];
      m_pend = (m_pend & ~clrm) | (s & ~m_prev);
      m_prev = s;
      case (m_phase)
         P_IDLE: if (low >= 0) begin m_sel = low; m_phase = P_FIRE; end
         P_FIRE: begin m_cv = 1'b1; m_ct = 1'b0; m_cid = m_sel; m_svc = 0; m_phase = P_SVC; end
         P_SVC: begin
            if (we && a == 2'd3) begin
               m_cv = 1'b0; m_hold = HOLDOFF; m_phase = P_HOLD;
            end
`ifdef INT_SCHED_TIMEOUT_EN
            else begin
               m_svc++;
               if (m_svc == SVC_TO) begin
                  m_cv = 1'b0; m_ct = 1'b1; m_hold = HOLDOFF; m_phase = P_HOLD;
               end
            end
`endif
         end
         default: begin
            m_hold--;
            if (m_hold == 0) m_phase = P_IDLE;
         end
      endcase
   endtask

   function automatic logic [31:0] m_rd(input logic [1:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         2'd0: v[3:0] = m_mask;
         2'd1: v[3:0] = m_pend;
         2'd2: begin v[31] = m_cv; v[30] = m_ct; v[1:0] = m_cid[1:0]; end
         default: v[1:0] = m_phase[1:0];
      endcase
      return v;
   endfunction

   task automatic step(input logic [3:0] s, input logic we, input logic [1:0] a,
                       input logic [31:0] wd, input logic r);
      src_in = s; cfg_we = we; cfg_addr = a; cfg_wdata = wd; reset = r;
      @(posedge clk);
      model_edge(s, we, a, wd, r);
      #1;
   endtask

   task automatic rd(input logic [1:0] a);
      cfg_we = 1'b0; cfg_addr = a;
      #1;
   endtask

   // Clears all pending bits, then issues EOIs until the scheduler is idle again.
   task automatic drain();
      step(4'b0, 1'b1, 2'd1, 32'hF, 1'b0);
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         step(4'b0, 1'b1, 2'd3, 32'h0, 1'b0);
      end
   endtask

   task automatic test_reset();
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         n_cmp++;
         if (cfg_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_reg%0d: got %h want 00000000", a, cfg_rdata);
         end
      end
      n_cmp++;
      if ({irq_pulse, irq_id, busy} !== 4'b0) begin
         n_err++; $display("FAIL reset_outs: got pulse=%b id=%0d busy=%b want 0/0/0",
                           irq_pulse, irq_id, busy);
      end
   endtask

   task automatic test_mask_gate();
      int pulses, first_k, id_seen;
      step(4'b0100, 1'b0, 2'd0, 32'h0, 1'b0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
         if (irq_pulse) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin n_err++; $display("FAIL masked_pulse: got %0d want 0", pulses); end
      rd(2'd1);
      n_cmp++;
      if (cfg_rdata !== 32'h4) begin
         n_err++; $display("FAIL masked_pend: got %h want 00000004", cfg_rdata);
      end
      step(4'b0, 1'b1, 2'd0, 32'h4, 1'b0);
      pulses = 0; first_k = -1; id_seen = -1;
      for (int k = 0; k < 6; k++) begin
         step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
         if (irq_pulse) begin
            pulses++; id_seen = int'(irq_id);
            if (first_k < 0) first_k = k;
         end
      end
      n_cmp++;
      if (pulses != 1 || first_k != 0 || id_seen != 2) begin
         n_err++; $display("FAIL unmask_pulse: got n=%0d at=%0d id=%0d want n=1 at=0 id=2",
                           pulses, first_k, id_seen);
      end
      rd(2'd2);
      n_cmp++;
      if (cfg_rdata !== 32'h8000_0002) begin
         n_err++; $display("FAIL unmask_cause: got %h want 80000002", cfg_rdata);
      end
      drain();
      rd(2'd2);
      n_cmp++;
      if (cfg_rdata !== 32'h0000_0002 || busy !== 1'b0) begin
         n_err++; $display("FAIL eoi_cause: got %h busy=%b want 00000002 busy=0", cfg_rdata, busy);
      end
   endtask

   task automatic test_priority();
      int early;
      step(4'b0, 1'b1, 2'd0, 32'hF, 1'b0);
      step(4'b1010, 1'b0, 2'd0, 32'h0, 1'b0);
      n_cmp++;
      if (irq_pulse !== 1'b0) begin n_err++; $display("FAIL prio_early: got %b want 0", irq_pulse); end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      n_cmp++;
      if (irq_pulse !== 1'b1 || irq_id !== 2'd1) begin
         n_err++; $display("FAIL prio_first: got pulse=%b id=%0d want 1/1", irq_pulse, irq_id);
      end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b1, 2'd3, 32'hDEAD, 1'b0);
      early = 0;
      for (int k = 0; k < HOLDOFF; k++) begin
         step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
         if (irq_pulse) early++;
      end
      n_cmp++;
      if (early != 0) begin n_err++; $display("FAIL prio_holdoff: got %0d pulses want 0", early); end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      n_cmp++;
      if (irq_pulse !== 1'b1 || irq_id !== 2'd3) begin
         n_err++; $display("FAIL prio_second: got pulse=%b id=%0d want 1/3", irq_pulse, irq_id);
      end
      drain();
   endtask

   task automatic test_merge();
      int pulses, at, id_seen;
      step(4'b1000, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      rd(2'd3);
      n_cmp++;
      if (cfg_rdata !== 32'h2) begin n_err++; $display("FAIL merge_state: got %h want 00000002", cfg_rdata); end
      rd(2'd1);
      n_cmp++;
      if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL merge_pend: got %h want 00000001", cfg_rdata); end
      step(4'b0, 1'b1, 2'd3, 32'h0, 1'b0);
      pulses = 0; at = -1; id_seen = -1;
      for (int k = 1; k <= HOLDOFF + 3; k++) begin
         step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
         if (irq_pulse) begin pulses++; at = k; id_seen = int'(irq_id); end
      end
      n_cmp++;
      if (pulses != 1 || at != HOLDOFF + 1 || id_seen != 0) begin
         n_err++; $display("FAIL merge_pulse: got n=%0d at=%0d id=%0d want n=1 at=%0d id=0",
                           pulses, at, id_seen, HOLDOFF + 1);
      end
      drain();
   endtask

   task automatic test_w1c_race();
      step(4'b0, 1'b1, 2'd0, 32'h0, 1'b0);
      step(4'b0010, 1'b1, 2'd1, 32'h2, 1'b0);
      rd(2'd1);
      n_cmp++;
      if (cfg_rdata !== 32'h2) begin n_err++; $display("FAIL w1c_race: got %h want 00000002", cfg_rdata); end
      step(4'b0010, 1'b1, 2'd1, 32'h2, 1'b0);
      rd(2'd1);
      n_cmp++;
      if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %h want 00000000", cfg_rdata); end
      step(4'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0);
      rd(2'd2);
      n_cmp++;
      if (cfg_rdata !== 32'h0000_0000) begin
         n_err++; $display("FAIL cause_ro: got %h want 00000000", cfg_rdata);
      end
   endtask

   task automatic test_reset_in_service();
      step(4'b0, 1'b1, 2'd0, 32'hF, 1'b0);
      step(4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
      rd(2'd3);
      n_cmp++;
      if (cfg_rdata !== 32'h2) begin n_err++; $display("FAIL rsvc_pre: got %h want 00000002", cfg_rdata); end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      n_cmp++;
      if (busy !== 1'b0 || irq_pulse !== 1'b0) begin
         n_err++; $display("FAIL rsvc_outs: got busy=%b pulse=%b want 0/0", busy, irq_pulse);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         n_cmp++;
         if (cfg_rdata !== 32'h0) begin
            n_err++; $display("FAIL rsvc_reg%0d: got %h want 00000000", a, cfg_rdata);
         end
      end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
   endtask

`ifdef INT_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      step(4'b0, 1'b1, 2'd0, 32'hF, 1'b0);
      step(4'b0100, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      n_cmp++;
      if (irq_pulse !== 1'b1 || irq_id !== 2'd2) begin
         n_err++; $display("FAIL tmo_fire: got pulse=%b id=%0d want 1/2", irq_pulse, irq_id);
      end
      for (int k = 0; k < SVC_TO; k++) step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      rd(2'd3);
      n_cmp++;
      if (cfg_rdata !== 32'h2) begin n_err++; $display("FAIL tmo_wait: got %h want 00000002", cfg_rdata); end
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      rd(2'd3);
      n_cmp++;
      if (cfg_rdata !== 32'h3) begin n_err++; $display("FAIL tmo_hold: got %h want 00000003", cfg_rdata); end
      rd(2'd2);
      n_cmp++;
      if (cfg_rdata !== 32'h4000_0002) begin
         n_err++; $display("FAIL tmo_cause: got %h want 40000002", cfg_rdata);
      end
      for (int k = 0; k < HOLDOFF; k++) step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
      step(4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b0);
      rd(2'd2);
      n_cmp++;
      if (cfg_rdata !== 32'h8000_0001) begin
         n_err++; $display("FAIL tmo_flag_clr: got %h want 80000001", cfg_rdata);
      end
      drain();
   endtask
`endif

   task automatic test_random();
      logic [3:0]  s;
      logic        we, r;
      logic [1:0]  a;
      logic [31:0] wd, exp_rd;
      s = '0;
      step(4'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) s = s ^ 4'($urandom);
         we = ($urandom_range(0, 3) == 0);
         a  = 2'($urandom);
         wd = $urandom;
         r  = ($urandom_range(0, 299) == 0);
         step(s, we, a, wd, r);
         n_cmp++;
         if (irq_pulse !== (m_phase == P_FIRE) || busy !== (m_phase != P_IDLE)) begin
            n_err++; $display("FAIL rnd_outs c=%0d: got pulse=%b busy=%b want phase=%0d",
                              c, irq_pulse, busy, m_phase);
         end
         if (m_phase == P_FIRE) begin
            n_cmp++;
            if (int'(irq_id) != m_sel) begin
               n_err++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, irq_id, m_sel);
            end
         end
         exp_rd = m_rd(a);
         n_cmp++;
         if (cfg_rdata !== exp_rd) begin
            n_err++; $display("FAIL rnd_rd c=%0d a=%0d: got %h want %h", c, a, cfg_rdata, exp_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mask_gate();
      test_priority();
      test_merge();
      test_w1c_race();
      test_reset_in_service();
`ifdef INT_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
